// File: rtl/frame_rd_responder.sv
// Responder for the rd_burst pixel-read handshake: fetches words from a fixed-latency
// memory port, returns them with valid/finish, and holds the frame-ready level.
module frame_rd_responder #(
   parameter int                ADDR_W      = 24,
   parameter int                DATA_W      = 16,
   parameter int                BURST_LEN   = 1,
   parameter int                ADDR_DLY    = 2,
   parameter int                MEM_LAT     = 2,
   parameter int                FRAME_WORDS = 307204,
   parameter logic [DATA_W-1:0] OOR_DATA    = {DATA_W{1'b1}}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_done,
   input  logic              frame_release,
   output logic              SDRAMFlag,
   input  logic              rd_burst_req,
   input  logic [ADDR_W-1:0] rd_burst_addr,
   output logic [DATA_W-1:0] rd_burst_data,
   output logic              rd_burst_data_valid,
   output logic              rd_burst_finish,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_busy,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              err_addr
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WAIT_ADDR = 3'd1;
   localparam logic [2:0] S_ISSUE     = 3'd2;
   localparam logic [2:0] S_DRAIN     = 3'd3;
   localparam logic [2:0] S_FINISH    = 3'd4;
   localparam logic [2:0] S_GAP       = 3'd5;

   localparam int CNT_W = $clog2(BURST_LEN + 1);
   localparam int DLY_W = $clog2(ADDR_DLY + 1);

   localparam logic [CNT_W-1:0]  BL_LAST    = CNT_W'(BURST_LEN - 1);
   localparam logic [CNT_W-1:0]  BL_CNT     = CNT_W'(BURST_LEN);
   localparam logic [DLY_W-1:0]  DLY_LAST   = DLY_W'(ADDR_DLY - 1);
   // Highest start address whose whole burst still lies inside the frame.
   localparam logic [ADDR_W:0]   LAST_START = (ADDR_W + 1)'(FRAME_WORDS - BURST_LEN);

   logic [2:0]        state_q, state_d;
   logic [DLY_W-1:0]  dly_q, dly_d;
   logic [CNT_W-1:0]  issued_q, issued_d;
   logic [CNT_W-1:0]  ret_q, ret_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              oor_q, oor_d;
   logic              err_q, err_d;
   logic              flag_q, flag_d;
   logic [MEM_LAT-1:0] pipe_q, pipe_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;

   logic issue_go;
   logic inject_go;
   logic ret_hit;

   assign issue_go  = (state_q == S_ISSUE) && !oor_q && !mem_busy;
   assign inject_go = (state_q == S_ISSUE) && oor_q;
   assign ret_hit   = pipe_q[MEM_LAT-1];

   always_comb begin
      state_d  = state_q;
      dly_d    = dly_q;
      issued_d = issued_q;
      ret_d    = ret_q;
      addr_d   = addr_q;
      oor_d    = oor_q;

      if (ret_hit || inject_go) begin
         ret_d = ret_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            dly_d    = '0;
            issued_d = '0;
            ret_d    = '0;
            if (rd_burst_req) begin
               state_d = S_WAIT_ADDR;
            end
         end
         S_WAIT_ADDR: begin
            if (dly_q == DLY_LAST) begin
               addr_d  = rd_burst_addr;
               oor_d   = {1'b0, rd_burst_addr} > LAST_START;
               state_d = S_ISSUE;
            end else begin
               dly_d = dly_q + 1'b1;
            end
         end
         S_ISSUE: begin
            if (issue_go || inject_go) begin
               issued_d = issued_q + 1'b1;
               if (issued_q == BL_LAST) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (ret_q == BL_CNT) begin
               state_d = S_FINISH;
            end
         end
         S_FINISH: state_d = S_GAP;
         S_GAP:    state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Valid shift register: bit MEM_LAT-1 marks the cycle mem_rdata carries a tracked read.
   assign pipe_d[0] = issue_go;
   genvar gi;
   for (gi = 1; gi < MEM_LAT; gi++) begin : g_pipe
      assign pipe_d[gi] = pipe_q[gi-1];
   end

   always_comb begin
      data_d  = data_q;
      valid_d = 1'b0;
      if (inject_go) begin
         data_d  = OOR_DATA;
         valid_d = 1'b1;
      end else if (ret_hit) begin
         data_d  = mem_rdata;
         valid_d = 1'b1;
      end
   end

   assign err_d  = err_q | inject_go;
   // Set wins over release when both pulse together.
   assign flag_d = frame_done ? 1'b1 : (frame_release ? 1'b0 : flag_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         dly_q    <= '0;
         issued_q <= '0;
         ret_q    <= '0;
         addr_q   <= '0;
         oor_q    <= 1'b0;
         err_q    <= 1'b0;
         flag_q   <= 1'b0;
         pipe_q   <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         dly_q    <= dly_d;
         issued_q <= issued_d;
         ret_q    <= ret_d;
         addr_q   <= addr_d;
         oor_q    <= oor_d;
         err_q    <= err_d;
         flag_q   <= flag_d;
         pipe_q   <= pipe_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
      end
   end

   assign mem_rd_en           = issue_go;
   assign mem_addr            = addr_q + ADDR_W'(issued_q);
   assign rd_burst_data       = data_q;
   assign rd_burst_data_valid = valid_q;
   assign rd_burst_finish     = (state_q == S_FINISH);
   assign err_addr            = err_q;
   assign SDRAMFlag           = flag_q;

endmodule

// File: tb/tb_frame_rd_responder.sv
// Bench for frame_rd_responder: two instances (single-word defaults, 4-word burst)
// driven by per-cycle schedules and compared against an event-level reference model.
module tb_frame_rd_responder;

   localparam int FW   = 307204;
   localparam int BL_A = 1, AD_A = 2, ML_A = 2;
   localparam int BL_B = 4, AD_B = 3, ML_B = 3;

   typedef struct packed {
      int c;
      int v;
   } ev_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic frame_done = 1'b0, frame_release = 1'b0;

   logic        req_a = 1'b0, busy_a = 1'b0;
   logic [23:0] addr_a = '0;
   logic        flag_a, val_a, fin_a, en_a, err_a;
   logic [15:0] data_a, rdata_a;
   logic [23:0] maddr_a;

   logic        req_b = 1'b0, busy_b = 1'b0;
   logic [23:0] addr_b = '0;
   logic        flag_b, val_b, fin_b, en_b, err_b;
   logic [15:0] data_b, rdata_b;
   logic [23:0] maddr_b;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int base = 0;
   int act = 0;
   int stray = 0;
   int mon_rel;
   bit mon_on = 1'b0;
   bit err_exp_a = 1'b0, err_exp_b = 1'b0;

   bit          req_s  [256];
   bit          busy_s [256];
   logic [23:0] addr_s [256];

   ev_t exp_en[$], exp_val[$], exp_fin[$];
   ev_t got_en[$], got_val[$], got_fin[$];

   logic [15:0] mem [int];
   logic [15:0] rp_a [2];
   logic [15:0] rp_b [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   frame_rd_responder u_dut_a (
      .clk(clk), .reset(reset), .frame_done(frame_done), .frame_release(frame_release),
      .SDRAMFlag(flag_a), .rd_burst_req(req_a), .rd_burst_addr(addr_a),
      .rd_burst_data(data_a), .rd_burst_data_valid(val_a), .rd_burst_finish(fin_a),
      .mem_rd_en(en_a), .mem_addr(maddr_a), .mem_busy(busy_a), .mem_rdata(rdata_a),
      .err_addr(err_a)
   );

   frame_rd_responder #(.BURST_LEN(BL_B), .ADDR_DLY(AD_B), .MEM_LAT(ML_B)) u_dut_b (
      .clk(clk), .reset(reset), .frame_done(frame_done), .frame_release(frame_release),
      .SDRAMFlag(flag_b), .rd_burst_req(req_b), .rd_burst_addr(addr_b),
      .rd_burst_data(data_b), .rd_burst_data_valid(val_b), .rd_burst_finish(fin_b),
      .mem_rd_en(en_b), .mem_addr(maddr_b), .mem_busy(busy_b), .mem_rdata(rdata_b),
      .err_addr(err_b)
   );

   function automatic logic [15:0] mem_word(input logic [23:0] a);
      if (mem.exists(int'(a))) return mem[int'(a)];
      return a[15:0] ^ 16'h5A5A ^ {a[23:16], 8'h00};
   endfunction

   // Memory model: fixed latency, garbage on cycles with no tracked read.
   always @(posedge clk) begin
      rp_a[0] <= en_a ? mem_word(maddr_a) : 16'($urandom);
      rp_a[1] <= rp_a[0];
      rp_b[0] <= en_b ? mem_word(maddr_b) : 16'($urandom);
      rp_b[1] <= rp_b[0];
      rp_b[2] <= rp_b[1];
   end
   assign rdata_a = rp_a[1];
   assign rdata_b = rp_b[2];

   always @(negedge clk) begin
      if (mon_on) begin
         mon_rel = cyc - base;
         if (act == 0) begin
            if (en_a)  got_en.push_back('{mon_rel, int'(maddr_a)});
            if (val_a) got_val.push_back('{mon_rel, int'(data_a)});
            if (fin_a) got_fin.push_back('{mon_rel, 0});
            if (en_b || val_b || fin_b) stray++;
         end else begin
            if (en_b)  got_en.push_back('{mon_rel, int'(maddr_b)});
            if (val_b) got_val.push_back('{mon_rel, int'(data_b)});
            if (fin_b) got_fin.push_back('{mon_rel, 0});
            if (en_a || val_a || fin_a) stray++;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] rand_addr(input int bl);
      case ($urandom_range(0, 5))
         0, 1, 2: return 24'($urandom_range(0, 1023));
         3:       return 24'(FW - bl);
         4:       return 24'(FW - bl + 1);
         default: return 24'($urandom);
      endcase
   endfunction

   task automatic clear_sched();
      for (int k = 0; k < 256; k++) begin
         req_s[k]  = 1'b0;
         busy_s[k] = 1'b0;
         addr_s[k] = 24'($urandom_range(0, 1023));
      end
   endtask

   // Reference: accept when free and req high; sample address ADDR_DLY later;
   // reads go out on the first non-busy cycles; data returns MEM_LAT+1 later;
   // finish follows the last word; free again two cycles after finish.
   task automatic predict(input int inst, input int n);
      int bl, ad, ml, t, c0, t2, last;
      logic [23:0] a;
      bl = (inst == 0) ? BL_A : BL_B;
      ad = (inst == 0) ? AD_A : AD_B;
      ml = (inst == 0) ? ML_A : ML_B;
      t = 0;
      last = 0;
      while (t < n) begin
         if (req_s[t]) begin
            c0 = t;
            a  = addr_s[c0 + ad];
            if (int'(a) > FW - bl) begin
               if (inst == 0) err_exp_a = 1'b1; else err_exp_b = 1'b1;
               for (int k = 0; k < bl; k++) exp_val.push_back('{c0 + ad + 2 + k, 32'hFFFF});
               last = c0 + ad + 1 + bl;
            end else begin
               t2 = c0 + ad + 1;
               for (int k = 0; k < bl; k++) begin
                  while (busy_s[t2]) t2++;
                  exp_en.push_back('{t2, int'(a) + k});
                  exp_val.push_back('{t2 + ml + 1, int'(mem_word(a + 24'(k)))});
                  last = t2 + ml + 1;
                  t2++;
               end
            end
            exp_fin.push_back('{last + 1, 0});
            t = last + 3;
         end else begin
            t++;
         end
      end
   endtask

   task automatic drive(input int inst, input bit r, input logic [23:0] a, input bit b);
      req_a  = (inst == 0) ? r : 1'b0;
      addr_a = (inst == 0) ? a : 24'd0;
      busy_a = (inst == 0) ? b : 1'b0;
      req_b  = (inst == 1) ? r : 1'b0;
      addr_b = (inst == 1) ? a : 24'd0;
      busy_b = (inst == 1) ? b : 1'b0;
   endtask

   task automatic run_sched(input string nm, input int inst, input int n);
      exp_en.delete(); exp_val.delete(); exp_fin.delete();
      got_en.delete(); got_val.delete(); got_fin.delete();
      stray = 0;
      predict(inst, n);
      act = inst;
      @(posedge clk); #1;
      base = cyc;
      mon_on = 1'b1;
      for (int k = 0; k < n; k++) begin
         drive(inst, req_s[k], addr_s[k], busy_s[k]);
         @(posedge clk); #1;
      end
      drive(inst, 1'b0, 24'd0, 1'b0);
      mon_on = 1'b0;

      chk($sformatf("%s en_count", nm), 32'(got_en.size()), 32'(exp_en.size()));
      for (int i = 0; i < exp_en.size() && i < got_en.size(); i++) begin
         chk($sformatf("%s en%0d cyc", nm, i), 32'(got_en[i].c), 32'(exp_en[i].c));
         chk($sformatf("%s en%0d addr", nm, i), 32'(got_en[i].v), 32'(exp_en[i].v));
      end
      chk($sformatf("%s val_count", nm), 32'(got_val.size()), 32'(exp_val.size()));
      for (int i = 0; i < exp_val.size() && i < got_val.size(); i++) begin
         chk($sformatf("%s val%0d cyc", nm, i), 32'(got_val[i].c), 32'(exp_val[i].c));
         chk($sformatf("%s val%0d data", nm, i), 32'(got_val[i].v), 32'(exp_val[i].v));
      end
      chk($sformatf("%s fin_count", nm), 32'(got_fin.size()), 32'(exp_fin.size()));
      for (int i = 0; i < exp_fin.size() && i < got_fin.size(); i++) begin
         chk($sformatf("%s fin%0d cyc", nm, i), 32'(got_fin[i].c), 32'(exp_fin[i].c));
      end
      chk($sformatf("%s stray", nm), 32'(stray), 32'd0);
      chk($sformatf("%s err_a", nm), 32'(err_a), 32'(err_exp_a));
      chk($sformatf("%s err_b", nm), 32'(err_b), 32'(err_exp_b));
      if (exp_val.size() > 0) begin
         chk($sformatf("%s data_hold", nm), 32'((inst == 0) ? data_a : data_b),
             32'(exp_val[exp_val.size()-1].v));
      end
   endtask

   task automatic gen_random(input int inst);
      int t, len, bl;
      bl = (inst == 0) ? BL_A : BL_B;
      clear_sched();
      t = $urandom_range(0, 3);
      while (t < 60) begin
         len = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 15) : 1;
         for (int j = 0; j < len && t + j < 60; j++) req_s[t + j] = 1'b1;
         t += len + $urandom_range(0, 12);
      end
      for (int k = 0; k < 80; k++) busy_s[k] = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 256; k++) addr_s[k] = rand_addr(bl);
   endtask

   task automatic check_all_zero(input string nm);
      chk($sformatf("%s valid_a", nm), 32'(val_a), 32'd0);
      chk($sformatf("%s fin_a", nm), 32'(fin_a), 32'd0);
      chk($sformatf("%s en_a", nm), 32'(en_a), 32'd0);
      chk($sformatf("%s maddr_a", nm), 32'(maddr_a), 32'd0);
      chk($sformatf("%s data_a", nm), 32'(data_a), 32'd0);
      chk($sformatf("%s flag_a", nm), 32'(flag_a), 32'd0);
      chk($sformatf("%s err_a", nm), 32'(err_a), 32'd0);
      chk($sformatf("%s data_b", nm), 32'(data_b), 32'd0);
      chk($sformatf("%s err_b", nm), 32'(err_b), 32'd0);
   endtask

   task automatic pulse_flags(input bit d, input bit r);
      @(posedge clk); #1;
      frame_done = d;
      frame_release = r;
      @(posedge clk); #1;
      frame_done = 1'b0;
      frame_release = 1'b0;
   endtask

   initial begin
      mem[4] = 16'd120;
      mem[100] = 16'd10; mem[101] = 16'd20; mem[102] = 16'd30; mem[103] = 16'd40;
      #3 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset = 1'b1;

      // Single read, defaults.
      clear_sched();
      req_s[0] = 1'b1; addr_s[2] = 24'd4;
      run_sched("single", 0, 20);
      if (got_en.size() > 0)  chk("single en_at_3", 32'(got_en[0].c), 32'd3);
      if (got_val.size() > 0) chk("single val_120", 32'(got_val[0].v), 32'd120);
      if (got_val.size() > 0) chk("single val_at_6", 32'(got_val[0].c), 32'd6);
      if (got_fin.size() > 0) chk("single fin_at_7", 32'(got_fin[0].c), 32'd7);

      // Backpressure during C0+3..C0+5.
      clear_sched();
      req_s[0] = 1'b1; addr_s[2] = 24'd4;
      busy_s[3] = 1'b1; busy_s[4] = 1'b1; busy_s[5] = 1'b1;
      run_sched("busy", 0, 24);
      if (got_en.size() > 0)  chk("busy en_at_6", 32'(got_en[0].c), 32'd6);
      if (got_val.size() > 0) chk("busy val_at_9", 32'(got_val[0].c), 32'd9);
      if (got_fin.size() > 0) chk("busy fin_at_10", 32'(got_fin[0].c), 32'd10);

      // Burst of four.
      clear_sched();
      req_s[0] = 1'b1; addr_s[AD_B] = 24'd100;
      run_sched("burst4", 1, 30);
      if (got_val.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("burst4 word%0d", k), 32'(got_val[k].v), 32'((k + 1) * 10));
            chk($sformatf("burst4 consec%0d", k), 32'(got_val[k].c), 32'(got_val[0].c + k));
         end
         if (got_fin.size() > 0) chk("burst4 fin_next", 32'(got_fin[0].c), 32'(got_val[3].c + 1));
      end

      // Out of range, then a good read keeps err_addr set.
      clear_sched();
      req_s[0] = 1'b1; addr_s[2] = 24'd307204;
      run_sched("oor", 0, 20);
      chk("oor no_rd_en", 32'(got_en.size()), 32'd0);
      if (got_val.size() > 0) chk("oor data_ffff", 32'(got_val[0].v), 32'hFFFF);
      chk("oor err_set", 32'(err_a), 32'd1);
      clear_sched();
      req_s[0] = 1'b1; addr_s[2] = 24'd4;
      run_sched("after_oor", 0, 20);
      chk("after_oor err_sticky", 32'(err_a), 32'd1);

      // Level request held across the first finish.
      clear_sched();
      for (int k = 0; k < 18; k++) req_s[k] = 1'b1;
      run_sched("level", 0, 30);
      chk("level fin_count2", 32'(got_fin.size()), 32'd2);
      if (got_en.size() > 1) begin
         chk("level accept0", 32'(got_en[0].c), 32'd3);
         chk("level accept9", 32'(got_en[1].c), 32'd12);
      end

      for (int r = 0; r < 24; r++) begin
         gen_random(r % 2);
         run_sched($sformatf("rand%0d", r), r % 2, 160);
      end

      // Frame-ready flag.
      chk("flag init", 32'(flag_a), 32'd0);
      pulse_flags(1'b1, 1'b0);
      chk("flag set", 32'(flag_a), 32'd1);
      chk("flag set_b", 32'(flag_b), 32'd1);
      pulse_flags(1'b1, 1'b1);
      chk("flag both", 32'(flag_a), 32'd1);
      pulse_flags(1'b0, 1'b1);
      chk("flag release", 32'(flag_a), 32'd0);
      pulse_flags(1'b1, 1'b0);

      // Reset in the middle of a read.
      got_en.delete(); got_val.delete(); got_fin.delete();
      act = 0;
      @(posedge clk); #1;
      base = cyc;
      mon_on = 1'b1;
      for (int k = 0; k < 5; k++) begin
         drive(0, k == 0, 24'd4, 1'b0);
         @(posedge clk); #1;
      end
      chk("rst_mid en_before", 32'(got_en.size()), 32'd1);
      chk("rst_mid flag_before", 32'(flag_a), 32'd1);
      #1 reset = 1'b0;
      #1;
      err_exp_a = 1'b0;
      err_exp_b = 1'b0;
      check_all_zero("rst_mid");
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      got_en.delete(); got_val.delete(); got_fin.delete();
      repeat (15) @(posedge clk);
      #1;
      mon_on = 1'b0;
      chk("rst_mid no_valid", 32'(got_val.size()), 32'd0);
      chk("rst_mid no_finish", 32'(got_fin.size()), 32'd0);
      chk("rst_mid no_rd_en", 32'(got_en.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
